// File: rtl/seq_decoder.sv
// Registered N-to-2^N one-hot decoder with active-low enable and a scan
// sequencer that walks every code from a loaded start index.
module seq_decoder #(
  parameter int N     = 3,
  parameter int M     = 2**N,
  parameter int DWELL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_n,
  input  logic         mode,
  input  logic [N-1:0] enc,
  input  logic         start,
  output logic [M-1:0] dec,
  output logic [N-1:0] idx,
  output logic         busy,
  output logic         done
);

  // state | meaning
  // IDLE  | direct decode (mode=0) or waiting for a scan start (mode=1)
  // SCAN  | presenting codes, each for DWELL enabled cycles
  typedef enum logic {IDLE, SCAN} state_t;

  localparam int CW = $clog2(M + 1);
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] CLAST = CW'(M);

  state_t        state_q, state_d;
  logic [M-1:0]  dec_q, dec_d;
  logic [N-1:0]  idx_q, idx_d, idx_inc;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0] ccnt_q, ccnt_d;
  logic          done_q, done_d;

  function automatic logic [M-1:0] onehot(input logic [N-1:0] i);
    logic [M-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign idx_inc = idx_q + N'(1);

  always_comb begin
    state_d = state_q;
    dec_d   = '0;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    ccnt_d  = ccnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          dec_d = en_n ? '0 : onehot(enc);
          idx_d = enc;
        end else if (!en_n && start) begin
          state_d = SCAN;
          idx_d   = enc;
          dec_d   = onehot(enc);
          dcnt_d  = '0;
          ccnt_d  = CW'(1);
        end
      end
      SCAN: begin
        // Priority: abort, then pause, then dwell/advance/finish.
        if (!mode) begin
          state_d = IDLE;
        end else if (en_n) begin
          dec_d = '0;
        end else if (dcnt_q != DLAST) begin
          dcnt_d = dcnt_q + DW'(1);
          dec_d  = onehot(idx_q);
        end else if (ccnt_q != CLAST) begin
          idx_d  = idx_inc;
          dcnt_d = '0;
          ccnt_d = ccnt_q + CW'(1);
          dec_d  = onehot(idx_inc);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dec_q   <= '0;
      idx_q   <= '0;
      dcnt_q  <= '0;
      ccnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      ccnt_q  <= ccnt_d;
      done_q  <= done_d;
    end
  end

  assign dec  = dec_q;
  assign idx  = idx_q;
  assign busy = (state_q == SCAN);
  assign done = done_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: direct-mode vector table plus hand-written
// scan, pause, abort, async-reset and back-to-back sequences.
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_n, mode, start;
  logic [2:0] enc;
  logic [7:0] dec;
  logic [2:0] idx;
  logic       busy, done;

  logic       en2_n, mode2, start2;
  logic [1:0] enc2;
  logic [3:0] dec2;
  logic [1:0] idx2;
  logic       busy2, done2;

  int tests = 0;
  int fails = 0;

  seq_decoder #(.N(3), .M(8), .DWELL(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_n(en_n), .mode(mode), .enc(enc),
    .start(start), .dec(dec), .idx(idx), .busy(busy), .done(done)
  );

  seq_decoder #(.N(2), .M(4), .DWELL(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en_n(en2_n), .mode(mode2), .enc(enc2),
    .start(start2), .dec(dec2), .idx(idx2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en_n;
    logic [2:0] enc;
    logic [7:0] dec;
    logic [2:0] idx;
  } vec_t;

  vec_t dv[16];
  int   exp_seq[32];
  bit   pz[32];
  int   wrap_order[8] = '{5, 6, 7, 0, 1, 2, 3, 4};
  int   pause_tab[19] = '{5, 5, 6, -1, -1, -1, 6, 7, 7, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [2:0] s, input int len, input logic [2:0] last);
    mode = 1'b1;
    enc  = s;
    for (int k = 0; k < len; k++) begin
      en_n  = pz[k];
      start = (k == 0);
      step();
      chk($sformatf("scan_busy[%0d]", k), 32'(busy), 32'd1);
      chk($sformatf("scan_dec[%0d]", k), 32'(dec),
          (exp_seq[k] < 0) ? 32'd0 : (32'd1 << exp_seq[k]));
      chk($sformatf("scan_done_low[%0d]", k), 32'(done), 32'd0);
    end
    en_n  = 1'b0;
    start = 1'b0;
    step();
    chk("end_done", 32'(done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_dec", 32'(dec), 32'd0);
    chk("end_idx", 32'(idx), 32'(last));
    step();
    chk("done_pulse_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dv[0]  = '{1'b0, 3'd0, 8'h01, 3'd0};
    dv[1]  = '{1'b0, 3'd1, 8'h02, 3'd1};
    dv[2]  = '{1'b0, 3'd2, 8'h04, 3'd2};
    dv[3]  = '{1'b0, 3'd3, 8'h08, 3'd3};
    dv[4]  = '{1'b0, 3'd4, 8'h10, 3'd4};
    dv[5]  = '{1'b0, 3'd5, 8'h20, 3'd5};
    dv[6]  = '{1'b0, 3'd6, 8'h40, 3'd6};
    dv[7]  = '{1'b0, 3'd7, 8'h80, 3'd7};
    dv[8]  = '{1'b1, 3'd0, 8'h00, 3'd0};
    dv[9]  = '{1'b1, 3'd1, 8'h00, 3'd1};
    dv[10] = '{1'b1, 3'd2, 8'h00, 3'd2};
    dv[11] = '{1'b1, 3'd3, 8'h00, 3'd3};
    dv[12] = '{1'b1, 3'd4, 8'h00, 3'd4};
    dv[13] = '{1'b1, 3'd5, 8'h00, 3'd5};
    dv[14] = '{1'b1, 3'd6, 8'h00, 3'd6};
    dv[15] = '{1'b1, 3'd7, 8'h00, 3'd7};

    rst_n = 1'b0; en_n = 1'b0; mode = 1'b0; start = 1'b0; enc = 3'd3;
    en2_n = 1'b1; mode2 = 1'b0; start2 = 1'b0; enc2 = 2'd0;
    #12;
    chk("rst_dec", 32'(dec), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      mode = 1'b0;
      en_n = dv[i].en_n;
      enc  = dv[i].enc;
      step();
      chk($sformatf("direct_dec[%0d]", i), 32'(dec), 32'(dv[i].dec));
      chk($sformatf("direct_idx[%0d]", i), 32'(idx), 32'(dv[i].idx));
      chk($sformatf("direct_busy[%0d]", i), 32'(busy), 32'd0);
    end

    for (int k = 0; k < 16; k++) begin
      exp_seq[k] = wrap_order[k / 2];
      pz[k]      = 1'b0;
    end
    run_scan(3'd5, 16, 3'd4);

    for (int k = 0; k < 19; k++) begin
      exp_seq[k] = pause_tab[k];
      pz[k]      = (k >= 3 && k <= 5);
    end
    run_scan(3'd5, 19, 3'd4);

    // abort, with start held high while busy
    en_n = 1'b0; mode = 1'b1; enc = 3'd2; start = 1'b1;
    step();
    chk("abort_c1_dec", 32'(dec), 32'h04);
    chk("abort_c1_busy", 32'(busy), 32'd1);
    enc = 3'd6;
    step();
    chk("busy_start_c2_dec", 32'(dec), 32'h04);
    step();
    chk("busy_start_c3_dec", 32'(dec), 32'h08);
    chk("busy_start_c3_idx", 32'(idx), 32'd3);
    step();
    chk("busy_start_c4_dec", 32'(dec), 32'h08);
    mode = 1'b0; start = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dec", 32'(dec), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("post_abort_direct_dec", 32'(dec), 32'h40);
    chk("post_abort_done", 32'(done), 32'd0);

    mode = 1'b1; en_n = 1'b1; start = 1'b1; enc = 3'd1;
    step();
    chk("start_en_n_busy", 32'(busy), 32'd0);
    chk("start_en_n_dec", 32'(dec), 32'd0);
    step();
    chk("start_en_n_busy2", 32'(busy), 32'd0);
    mode = 1'b0; en_n = 1'b0;
    step();
    chk("start_mode0_busy", 32'(busy), 32'd0);
    chk("start_mode0_dec", 32'(dec), 32'h02);
    mode = 1'b1; start = 1'b0;
    step();
    chk("idle_mode1_dec", 32'(dec), 32'd0);
    chk("idle_mode1_idx", 32'(idx), 32'd1);

    // async reset during code 2
    enc = 3'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_dec", 32'(dec), 32'h04);
    chk("pre_rst_idx", 32'(idx), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dec", 32'(dec), 32'd0);
    chk("async_rst_idx", 32'(idx), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp_seq[k] = k / 2;
      pz[k]      = 1'b0;
    end
    run_scan(3'd0, 16, 3'd7);

    // back-to-back scans on the N=2, DWELL=1 instance
    mode2 = 1'b1; en2_n = 1'b0; enc2 = 2'd0; start2 = 1'b1;
    for (int j = 0; j < 15; j++) begin
      step();
      if (j % 5 == 4) begin
        chk($sformatf("b2b_done[%0d]", j), 32'(done2), 32'd1);
        chk($sformatf("b2b_busy[%0d]", j), 32'(busy2), 32'd0);
        chk($sformatf("b2b_dec[%0d]", j), 32'(dec2), 32'd0);
        chk($sformatf("b2b_idx[%0d]", j), 32'(idx2), 32'd3);
      end else begin
        chk($sformatf("b2b_busy[%0d]", j), 32'(busy2), 32'd1);
        chk($sformatf("b2b_dec[%0d]", j), 32'(dec2), 32'd1 << (j % 5));
        chk($sformatf("b2b_done_low[%0d]", j), 32'(done2), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
